// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with configurable step, PC-relative branch and
// a hardware return-address stack; error conditions latch into sticky flags.
module pc_stack_unit #(
  parameter int                 WIDTH        = 16,
  parameter int                 STEP         = 1,
  parameter int                 DEPTH        = 8,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  localparam int                DW           = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_top,
  output logic [DW-1:0]    o_depth,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_illegal
);

  // Storage is rounded up to a power of two so the pointer indexes it without
  // range checks; slots at or above DEPTH are never written.
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] stack_q [SLOTS];

  logic             full, empty, push;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] ret_addr;

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign wr_idx   = AW'(depth_q);
  assign rd_idx   = AW'(depth_q - DW'(1));
  assign ret_addr = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ill_d   = ill_q;
    push    = 1'b0;
    if (!i_stall) begin
      case (i_op)
        OP_HOLD:   pc_d = pc_q;
        OP_INC:    pc_d = ret_addr;
        OP_JUMP:   pc_d = i_data;
        // Same-width add is the sign-extended add modulo 2^WIDTH.
        OP_BRANCH: pc_d = pc_q + i_data;
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = i_data;
            depth_d = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d    = stack_q[rd_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default:   ill_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && push) stack_q[wr_idx] <= ret_addr;
  end

  assign o_pc        = pc_q;
  assign o_top       = empty ? '0 : stack_q[rd_idx];
  assign o_depth     = depth_q;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
  assign o_illegal   = ill_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int          W     = 16;
  localparam int          STEP  = 1;
  localparam int          DEPTH = 2;
  localparam logic [15:0] RV    = 16'h0100;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall;
  logic [2:0]  i_op;
  logic [15:0] i_data;
  logic [15:0] o_pc, o_top;
  logic [1:0]  o_depth;
  logic        o_full, o_empty, o_overflow, o_underflow, o_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk [$];
  logic        m_ovf, m_unf, m_ill;

  always #5 i_clk = ~i_clk;

  pc_stack_unit #(.WIDTH(W), .STEP(STEP), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_op(i_op), .i_data(i_data),
    .o_pc(o_pc), .o_top(o_top), .o_depth(o_depth), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_illegal(o_illegal)
  );

  // Apply one cycle of stimulus, advance the reference model, settle past the edge.
  task automatic drive(input logic rst, input logic stall, input logic [2:0] op,
                       input logic [15:0] data);
    @(negedge i_clk);
    i_reset = rst; i_stall = stall; i_op = op; i_data = data;
    @(posedge i_clk);
    if (rst) begin
      m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0; m_ill = 0;
    end else if (!stall) begin
      case (op)
        3'd0: ;
        3'd1: m_pc = 16'((int'(m_pc) + STEP) % 65536);
        3'd2: m_pc = data;
        3'd3: m_pc = 16'((int'(m_pc) + int'($signed(data)) + 65536) % 65536);
        3'd4: if (m_stk.size() == DEPTH) m_ovf = 1;
              else begin
                m_stk.push_back(16'((int'(m_pc) + STEP) % 65536));
                m_pc = data;
              end
        3'd5: if (m_stk.size() == 0) m_unf = 1;
              else m_pc = m_stk.pop_back();
        default: m_ill = 1;
      endcase
    end
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 3'd0, 16'h0);
    n_checks++; if (o_pc !== 16'h0100) $display("FAIL reset_pc got=%h exp=0100", o_pc); else n_pass++;
    n_checks++; if (o_depth !== 2'd0) $display("FAIL reset_depth got=%0d exp=0", o_depth); else n_pass++;
    n_checks++; if ({o_empty, o_full} !== 2'b10) $display("FAIL reset_empty_full got=%b exp=10", {o_empty, o_full}); else n_pass++;
    n_checks++; if (o_top !== 16'h0) $display("FAIL reset_top got=%h exp=0000", o_top); else n_pass++;
    n_checks++; if ({o_overflow, o_underflow, o_illegal} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {o_overflow, o_underflow, o_illegal}); else n_pass++;
    for (int i = 0; i < 3; i++) drive(0, 0, 3'd1, 16'h0);
    n_checks++; if (o_pc !== 16'h0103) $display("FAIL inc3_pc got=%h exp=0103", o_pc); else n_pass++;
  endtask

  task automatic test_branch_wrap;
    drive(0, 0, 3'd2, 16'h0010);
    drive(0, 0, 3'd3, 16'hFFF0);
    n_checks++; if (o_pc !== 16'h0000) $display("FAIL branch_neg got=%h exp=0000", o_pc); else n_pass++;
    drive(0, 0, 3'd3, 16'h0025);
    n_checks++; if (o_pc !== 16'h0025) $display("FAIL branch_pos got=%h exp=0025", o_pc); else n_pass++;
    drive(0, 0, 3'd2, 16'hFFFF);
    drive(0, 0, 3'd1, 16'h0);
    n_checks++; if (o_pc !== 16'h0000) $display("FAIL inc_wrap got=%h exp=0000", o_pc); else n_pass++;
    n_checks++; if ({o_overflow, o_underflow, o_illegal} !== 3'b000) $display("FAIL wrap_flags got=%b exp=000", {o_overflow, o_underflow, o_illegal}); else n_pass++;
  endtask

  task automatic test_nested_call;
    drive(0, 0, 3'd2, 16'h0020);
    drive(0, 0, 3'd4, 16'h0200);
    n_checks++; if (o_top !== 16'h0021) $display("FAIL call1_top got=%h exp=0021", o_top); else n_pass++;
    drive(0, 0, 3'd4, 16'h0300);
    n_checks++; if (o_depth !== 2'd2) $display("FAIL call2_depth got=%0d exp=2", o_depth); else n_pass++;
    n_checks++; if (o_top !== 16'h0201) $display("FAIL call2_top got=%h exp=0201", o_top); else n_pass++;
    n_checks++; if ({o_pc, o_full} !== {16'h0300, 1'b1}) $display("FAIL call2_pc_full got=%h/%b exp=0300/1", o_pc, o_full); else n_pass++;
    drive(0, 0, 3'd5, 16'h0);
    n_checks++; if (o_pc !== 16'h0201) $display("FAIL ret1_pc got=%h exp=0201", o_pc); else n_pass++;
    drive(0, 0, 3'd5, 16'h0);
    n_checks++; if (o_pc !== 16'h0021) $display("FAIL ret2_pc got=%h exp=0021", o_pc); else n_pass++;
    n_checks++; if ({o_empty, o_top} !== {1'b1, 16'h0}) $display("FAIL ret2_empty_top got=%b/%h exp=1/0000", o_empty, o_top); else n_pass++;
  endtask

  task automatic test_overflow_underflow;
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 0, 3'd4, 16'h1000);
    drive(0, 0, 3'd4, 16'h2000);
    drive(0, 0, 3'd4, 16'h3000);
    n_checks++; if (o_pc !== 16'h2000) $display("FAIL ovf_pc got=%h exp=2000", o_pc); else n_pass++;
    n_checks++; if (o_depth !== 2'd2) $display("FAIL ovf_depth got=%0d exp=2", o_depth); else n_pass++;
    n_checks++; if ({o_overflow, o_top} !== {1'b1, 16'h1001}) $display("FAIL ovf_flag_top got=%b/%h exp=1/1001", o_overflow, o_top); else n_pass++;
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 0, 3'd5, 16'h0);
    n_checks++; if ({o_underflow, o_overflow} !== 2'b10) $display("FAIL unf_flags got=%b exp=10", {o_underflow, o_overflow}); else n_pass++;
    n_checks++; if (o_pc !== 16'h0100) $display("FAIL unf_pc got=%h exp=0100", o_pc); else n_pass++;
  endtask

  task automatic test_stall_illegal;
    drive(1, 0, 3'd0, 16'h0);
    drive(0, 1, 3'd4, 16'h0400);
    n_checks++; if ({o_pc, o_depth} !== {16'h0100, 2'd0}) $display("FAIL stall_pc_depth got=%h/%0d exp=0100/0", o_pc, o_depth); else n_pass++;
    drive(0, 1, 3'd7, 16'h0);
    n_checks++; if ({o_overflow, o_underflow, o_illegal} !== 3'b000) $display("FAIL stall_flags got=%b exp=000", {o_overflow, o_underflow, o_illegal}); else n_pass++;
    drive(0, 0, 3'd6, 16'h0);
    n_checks++; if ({o_illegal, o_pc} !== {1'b1, 16'h0100}) $display("FAIL illegal got=%b/%h exp=1/0100", o_illegal, o_pc); else n_pass++;
    drive(0, 0, 3'd1, 16'h0);
    n_checks++; if ({o_illegal, o_pc} !== {1'b1, 16'h0101}) $display("FAIL illegal_sticky got=%b/%h exp=1/0101", o_illegal, o_pc); else n_pass++;
    drive(1, 1, 3'd4, 16'h0400);
    n_checks++; if ({o_illegal, o_pc, o_depth} !== {1'b0, 16'h0100, 2'd0}) $display("FAIL reset_over_stall got=%b/%h/%0d exp=0/0100/0", o_illegal, o_pc, o_depth); else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive(0, 0, 3'd2, 16'h0040);
    drive(0, 0, 3'd4, 16'h0800);
    drive(0, 0, 3'd5, 16'h0);
    n_checks++; if (o_pc !== 16'h0041) $display("FAIL call_ret_pc got=%h exp=0041", o_pc); else n_pass++;
    drive(0, 0, 3'd2, 16'hFFFF);
    drive(0, 0, 3'd4, 16'h0010);
    n_checks++; if ({o_top, o_depth} !== {16'h0000, 2'd1}) $display("FAIL push_wrap got=%h/%0d exp=0000/1", o_top, o_depth); else n_pass++;
    n_checks++; if ({o_full, o_empty} !== 2'b00) $display("FAIL mid_full_empty got=%b exp=00", {o_full, o_empty}); else n_pass++;
    drive(0, 0, 3'd5, 16'h0);
    n_checks++; if (o_pc !== 16'h0000) $display("FAIL ret_wrap_pc got=%h exp=0000", o_pc); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] exp_top;
    logic [2:0]  op;
    logic        rst, stall;
    drive(1, 0, 3'd0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      // Bias toward CALL/RET so the stack cycles through empty and full.
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd4;
        3, 4, 5: op = 3'd5;
        6:       op = 3'd1;
        7:       op = 3'd3;
        8:       op = 3'd2;
        default: op = 3'($urandom_range(0, 7));
      endcase
      drive(rst, stall, op, 16'($urandom));
      exp_top = (m_stk.size() == 0) ? 16'h0 : m_stk[$];
      n_checks++; if (o_pc !== m_pc) $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, o_pc, m_pc); else n_pass++;
      n_checks++; if (o_top !== exp_top) $display("FAIL rnd_top[%0d] got=%h exp=%h", i, o_top, exp_top); else n_pass++;
      n_checks++; if (int'(o_depth) != m_stk.size()) $display("FAIL rnd_depth[%0d] got=%0d exp=%0d", i, o_depth, m_stk.size()); else n_pass++;
      n_checks++;
      if ({o_full, o_empty} !== {m_stk.size() == DEPTH, m_stk.size() == 0})
        $display("FAIL rnd_full_empty[%0d] got=%b%b exp=%b%b", i, o_full, o_empty, m_stk.size() == DEPTH, m_stk.size() == 0);
      else n_pass++;
      n_checks++;
      if ({o_overflow, o_underflow, o_illegal} !== {m_ovf, m_unf, m_ill})
        $display("FAIL rnd_flags[%0d] got=%b exp=%b", i, {o_overflow, o_underflow, o_illegal}, {m_ovf, m_unf, m_ill});
      else n_pass++;
    end
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_op = 3'd0; i_data = 16'h0;
    m_pc = RV; m_ovf = 0; m_unf = 0; m_ill = 0;
    test_reset();
    test_branch_wrap();
    test_nested_call();
    test_overflow_underflow();
    test_stall_illegal();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit: the successor to the basic load/increment counter. It adds configurable step, PC-relative branching, and a hardware return-address stack for call/return. It sits in the fetch stage, drives the instruction-memory address, and takes one control opcode per cycle from the decoder. Error conditions are reported through sticky flags instead of simulation-only checks.

## Interface
Parameters:
- WIDTH, 16, PC and data width in bits
- STEP, 1, increment applied by INC and used to form the CALL return address
- DEPTH, 8, return-stack entries (≥1)
- RESET_VECTOR, 0, PC value after reset

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_stall  in  1  freeze all state this cycle
- i_op  in  3  opcode: 0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 illegal
- i_data  in  WIDTH  absolute target (JUMP/CALL) or two's-complement offset (BRANCH)
- o_pc  out  WIDTH  current PC
- o_top  out  WIDTH  top-of-stack entry; 0 when the stack is empty
- o_depth  out  $clog2(DEPTH+1)  number of valid stack entries
- o_full  out  1  o_depth == DEPTH
- o_empty  out  1  o_depth == 0
- o_overflow  out  1  sticky: CALL attempted while full
- o_underflow  out  1  sticky: RET attempted while empty
- o_illegal  out  1  sticky: opcode 6 or 7 received

## Operation
- Priority: i_reset > i_stall > i_op.
- **Reset:**
  - o_pc = RESET_VECTOR.
  - o_depth = 0, so o_empty = 1, o_full = 0, o_top = 0.
  - All sticky flags = 0.
  - Stack storage contents are don't-care.
- **Stall:** no change to PC, stack, depth or flags, regardless of i_op.
- **Opcodes:**
  - HOLD: PC unchanged.
  - INC: PC <= PC + STEP.
  - JUMP: PC <= i_data.
  - BRANCH: PC <= PC + sign-extended i_data.
  - CALL, not full: push PC + STEP, PC <= i_data, depth +1.
  - CALL, full: PC and stack unchanged; set o_overflow.
  - RET, not empty: PC <= top entry, pop, depth −1.
  - RET, empty: PC unchanged; set o_underflow.
  - 6/7: PC and stack unchanged; set o_illegal.
- **Arithmetic:**
  - All PC arithmetic is modulo 2^WIDTH; carries are discarded.
  - Wrap-around is legal and not flagged.
  - The pushed return address also wraps.
- **Stack:**
  - LIFO register array with a pointer equal to o_depth.
  - Push writes entry[depth]; pop reads entry[depth−1].
  - Only one push or pop can occur per cycle, so there is no simultaneous push/pop case.
- **Sticky flags:** cleared only by i_reset. Multiple flags may be set at once.

## Timing
- All outputs are registered. An opcode presented in cycle N is reflected on o_pc, o_top, o_depth and the flags after the rising edge ending cycle N (1-cycle latency).
- No combinational path from inputs to outputs.
- Back-to-back ops are allowed every cycle, e.g. CALL followed immediately by RET returns to the call site + STEP on the second edge.
- Reset asserted mid-sequence: the following edge applies reset values regardless of i_op or i_stall; stack contents are discarded.
- Stall released: the next op executes against the frozen state.
- DEPTH = 1: o_full and o_empty are complementary.

## Test plan
- **Reset:** with WIDTH=16, RESET_VECTOR=0x0100, assert reset -> o_pc=0x0100, o_depth=0, o_empty=1, all flags 0; then INC ×3 with STEP=1 -> o_pc=0x0103.
- **Branch and wrap:** PC=0x0010, BRANCH 0xFFF0 (−16) -> o_pc=0x0000; PC=0xFFFF, INC -> o_pc=0x0000, no flag set.
- **Nested call/return:** at PC=0x0020, CALL 0x0200, then CALL 0x0300 -> depth=2, o_top=0x0201; RET -> o_pc=0x0201; RET -> o_pc=0x0021, o_empty=1.
- **Overflow/underflow:** DEPTH=2, three CALLs -> third leaves PC and depth unchanged, o_overflow=1. Reset, then RET -> o_underflow=1, PC unchanged.
- **Stall and illegal:** i_stall=1 with CALL 0x0400 -> o_pc, o_depth, flags unchanged. Release stall, op=6 -> o_illegal=1, PC unchanged. Assert reset -> o_illegal=0.
